// File: rtl/rsv_station.sv
// ---------------------------------------------------------------------------
// rsv_station
//   Reservation station for non-load/store instructions. Buffers dispatched
//   instructions with operand values or ROB dependency tags, snoops the ALU
//   and load CDB buses to wake waiting operands, and issues the lowest-index
//   ready entry to the ALU once per cycle. Rollback flushes every entry.
//
//   Optional feature macro: RS_BYPASS_EN
//     When defined, a dispatched instruction that is fully ready after the
//     same-cycle CDB check issues directly on the dispatch edge, provided no
//     array entry is ready. It never occupies an entry.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global ready; low freezes all state
//   rb                  rollback; flush all entries
//   full                combinational; fewer than two free entries
//   disp_*              dispatch write port (strobe, opcode, tags, values,
//                       immediate, destination ROB index)
//   cdb_alu_*           ALU result broadcast (valid, tag, value)
//   cdb_ld_*            load result broadcast (valid, tag, value)
//   alu_ena             registered one-cycle issue strobe
//   alu_*               registered issue payload
// ---------------------------------------------------------------------------
module rsv_station #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OPT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rb,
    output logic             full,

    input  logic             disp_ena,
    input  logic [OPT_W-1:0] disp_opt,
    input  logic [ROB_W-1:0] disp_src1,
    input  logic [ROB_W-1:0] disp_src2,
    input  logic [31:0]      disp_val1,
    input  logic [31:0]      disp_val2,
    input  logic [31:0]      disp_imm,
    input  logic [ROB_W-1:0] disp_rob_idx,

    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_src,
    input  logic [31:0]      cdb_alu_val,
    input  logic             cdb_ld_valid,
    input  logic [ROB_W-1:0] cdb_ld_src,
    input  logic [31:0]      cdb_ld_val,

    output logic             alu_ena,
    output logic [OPT_W-1:0] alu_opt,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [ROB_W-1:0] alu_rob_idx
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    // Entry storage
    logic [RS_SIZE-1:0] r_busy;
    logic [OPT_W-1:0]   r_opt  [RS_SIZE];
    logic [ROB_W-1:0]   r_src1 [RS_SIZE];
    logic [ROB_W-1:0]   r_src2 [RS_SIZE];
    logic [31:0]        r_val1 [RS_SIZE];
    logic [31:0]        r_val2 [RS_SIZE];
    logic [31:0]        r_imm  [RS_SIZE];
    logic [ROB_W-1:0]   r_rob  [RS_SIZE];

    // Combinational helpers
    logic [RS_SIZE-1:0] w_ready;
    logic               w_iss_found;
    logic [IDX_W-1:0]   w_iss_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [CNT_W-1:0]   w_free_cnt;
    logic [32:0]        w_wk1 [RS_SIZE];
    logic [32:0]        w_wk2 [RS_SIZE];
    logic [32:0]        w_dk1;
    logic [32:0]        w_dk2;
    logic [ROB_W-1:0]   w_d_src1;
    logic [ROB_W-1:0]   w_d_src2;
    logic [31:0]        w_d_val1;
    logic [31:0]        w_d_val2;
    logic               w_bypass;

    // CDB snoop: {hit, value}; ALU bus has priority over the load bus.
    function automatic logic [32:0] snoop(input logic [ROB_W-1:0] tag);
        logic [32:0] res;
        res = '0;
        if (tag != '0) begin
            if (cdb_alu_valid && cdb_alu_src == tag)
                res = {1'b1, cdb_alu_val};
            else if (cdb_ld_valid && cdb_ld_src == tag)
                res = {1'b1, cdb_ld_val};
        end
        return res;
    endfunction

    // Readiness, issue select, free-slot select and free count
    always_comb begin
        w_ready      = '0;
        w_iss_found  = 1'b0;
        w_iss_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_free_cnt   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] && (r_src1[i] == '0) && (r_src2[i] == '0);
            if (!w_iss_found && w_ready[i]) begin
                w_iss_found = 1'b1;
                w_iss_idx   = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_free_cnt = w_free_cnt + CNT_W'(1);
                if (!w_free_found) begin
                    w_free_found = 1'b1;
                    w_free_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign full = (w_free_cnt < CNT_W'(2));

    // Wakeup candidates for resident entries
    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            w_wk1[i] = snoop(r_src1[i]);
            w_wk2[i] = snoop(r_src2[i]);
        end
    end

    // Same-cycle CDB resolution of incoming operands
    always_comb begin
        w_dk1    = snoop(disp_src1);
        w_dk2    = snoop(disp_src2);
        w_d_src1 = w_dk1[32] ? '0 : disp_src1;
        w_d_val1 = w_dk1[32] ? w_dk1[31:0] : disp_val1;
        w_d_src2 = w_dk2[32] ? '0 : disp_src2;
        w_d_val2 = w_dk2[32] ? w_dk2[31:0] : disp_val2;
    end

`ifdef RS_BYPASS_EN
    assign w_bypass = disp_ena && !w_iss_found &&
                      (w_d_src1 == '0) && (w_d_src2 == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            alu_ena     <= 1'b0;
            alu_opt     <= '0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_rob_idx <= '0;
        end else if (!rdy) begin
            alu_ena <= 1'b0;
        end else if (rb) begin
            r_busy  <= '0;
            alu_ena <= 1'b0;
        end else begin
            // Wakeup only touches busy entries; dispatch only writes a
            // non-busy one, so the two never collide on the same slot.
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    if (w_wk1[i][32]) begin
                        r_src1[i] <= '0;
                        r_val1[i] <= w_wk1[i][31:0];
                    end
                    if (w_wk2[i][32]) begin
                        r_src2[i] <= '0;
                        r_val2[i] <= w_wk2[i][31:0];
                    end
                end
            end

            alu_ena <= 1'b0;
            if (w_iss_found) begin
                alu_ena             <= 1'b1;
                alu_opt             <= r_opt[w_iss_idx];
                alu_val1            <= r_val1[w_iss_idx];
                alu_val2            <= r_val2[w_iss_idx];
                alu_imm             <= r_imm[w_iss_idx];
                alu_rob_idx         <= r_rob[w_iss_idx];
                r_busy[w_iss_idx]   <= 1'b0;
            end else if (w_bypass) begin
                alu_ena     <= 1'b1;
                alu_opt     <= disp_opt;
                alu_val1    <= w_d_val1;
                alu_val2    <= w_d_val2;
                alu_imm     <= disp_imm;
                alu_rob_idx <= disp_rob_idx;
            end

            // Free slot comes from registered busy, so a slot vacated by
            // this edge's issue is not a candidate.
            if (disp_ena && w_free_found && !w_bypass) begin
                r_busy[w_free_idx] <= 1'b1;
                r_opt[w_free_idx]  <= disp_opt;
                r_src1[w_free_idx] <= w_d_src1;
                r_src2[w_free_idx] <= w_d_src2;
                r_val1[w_free_idx] <= w_d_val1;
                r_val2[w_free_idx] <= w_d_val2;
                r_imm[w_free_idx]  <= disp_imm;
                r_rob[w_free_idx]  <= disp_rob_idx;
            end
        end
    end

endmodule

// File: doc/rsv_station.md
# rsv_station

Reservation station: the receiving end of the dispatcher's RS issue port. It buffers non-load/store instructions together with operand values or ROB dependency tags, and snoops both CDB result buses (ALU and load) to wake waiting operands. Each cycle it issues the oldest-slot ready instruction to the ALU. It sits between the decode/dispatch stage and the ALU and supports full-pipeline rollback.

## Interface

Parameters:
- `RS_SIZE`, 8: number of entries; 2..16.
- `ROB_W`, 4: ROB index width. Index 0 means "no dependency / value valid".
- `OPT_W`, 6: opcode width, matching the dispatcher's opt encoding.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; low freezes all state.
- `rb` in 1: rollback; flush all entries.
- `full` out 1: combinational; high when free entries < 2.
- `disp_ena` in 1: dispatch write strobe.
- `disp_opt` in OPT_W: opcode.
- `disp_src1`, `disp_src2` in ROB_W: operand tags; 0 means the value is valid.
- `disp_val1`, `disp_val2`, `disp_imm` in 32: operand values and immediate.
- `disp_rob_idx` in ROB_W: destination ROB entry.
- `cdb_alu_valid` in 1, `cdb_alu_src` in ROB_W, `cdb_alu_val` in 32: ALU broadcast.
- `cdb_ld_valid` in 1, `cdb_ld_src` in ROB_W, `cdb_ld_val` in 32: load broadcast.
- `alu_ena` out 1: registered issue strobe, one cycle wide.
- `alu_opt` out OPT_W; `alu_val1`, `alu_val2`, `alu_imm` out 32; `alu_rob_idx` out ROB_W: registered issue payload.

## Operation

- Per-entry state: busy, opt, src1/2, val1/2, imm, rob_idx.
- Dispatch: when `disp_ena` is high, write to the lowest-index free entry.
  - An incoming operand whose nonzero tag matches a valid CDB tag in the same cycle is stored with tag 0 and the CDB value. The ALU bus is checked before the load bus.
  - `disp_ena` with no free entry: the instruction is dropped and state is unchanged. This is a protocol violation by the sender.
- Wakeup: every busy entry compares each nonzero src against both CDB buses. On a match, set src to 0 and capture the value. Both operands may wake in the same cycle from different buses.
- Ready: busy and src1==0 and src2==0, evaluated on registered state only.
- Issue: each edge, the lowest-index ready entry drives the alu_* registers with `alu_ena`=1, and its busy bit clears. If no entry is ready, `alu_ena`=0 and the payload registers hold.
- An entry freed by issue is not reusable by a dispatch on the same edge. The dispatch takes the next free slot.
- Priority, highest first:
  1. `rst`: all busy=0, `alu_ena`=0, payload=0.
  2. `!rdy`: state held, `alu_ena`=0, dispatch ignored.
  3. `rb`: all busy=0, `alu_ena`=0; dispatch and issue in that cycle are discarded.
  4. Normal operation.
- Reset values: `alu_ena`=0, `alu_opt`=0, `alu_val1`=0, `alu_val2`=0, `alu_imm`=0, `alu_rob_idx`=0, all busy=0.

## Timing

- Dispatch at edge N: the entry is visible at N. Earliest issue is at edge N+1, so `alu_ena` is high during cycle N+1..N+2.
- CDB wakeup at edge N: the entry is ready from N, with issue at edge N+1.
- `full` margin of 2 covers the dispatcher's one-stage register between its full check and `disp_ena`.
- Throughput: one issue per cycle and one dispatch per cycle.

## Configuration

- `RS_BYPASS_EN` defined:
  - Condition: a dispatched instruction whose operands are both ready after the same-cycle CDB check, while no array entry is ready.
  - Effect: it issues directly on the same edge (latency 0 edges after dispatch) and never occupies an entry.
  - `full` semantics are unchanged.
- Undefined: every dispatch goes through an entry, with a minimum of one cycle from dispatch to issue.

## Test plan

- Reset, then dispatch opt=ADD with src1=0, src2=0, val1=5, val2=7, rob_idx=3:
  - without bypass, `alu_ena` rises one edge later with val1=5, val2=7, rob_idx=3;
  - with bypass, `alu_ena` rises on the same edge.
- Dispatch with src1=2, val1=0, then assert `cdb_ld_valid`, src=2, val=0x1234 two cycles later: issue occurs on the edge after the broadcast with val1=0x1234.
- Dispatch with src1=4 in the same cycle as `cdb_alu_valid` src=4, val=9: the entry stores 9 and issues at the next edge (or bypasses when `RS_BYPASS_EN` is defined).
- Fill 8 entries, all waiting on tag 5:
  - `full` asserts when 7 entries are occupied;
  - a CDB broadcast of tag 5 then yields 8 consecutive `alu_ena` pulses in entry-index order.
- With 3 waiting entries, assert `rb` together with `disp_ena`: all entries are cleared, `alu_ena` stays 0, and `full`=0 afterwards.
- Hold `rdy`=0 for 3 cycles while a CDB broadcast matches a waiting entry: the broadcast is lost, nothing issues, and the entry is still waiting once `rdy` returns.
